// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch slice.
// Holds no logic, so it adds no latency and applies no backpressure.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } inst_ent_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for fetched instructions. A push is visible one cycle later (no bypass).
// A push is dropped only when the FIFO is full and no pop frees a slot. flush empties it next cycle.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees its slot in the same cycle, so push+pop on a full FIFO keeps occupancy.
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with PC tracking, in-order memory responses, redirect flush and an instruction queue.
// A response reaches inst_* one cycle later. Requests are credit-limited by queue occupancy plus outstanding.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc4
);
  localparam int CW = $clog2(QDEPTH);
  localparam logic [CW+1:0] QD = (CW+2)'(QDEPTH);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt, rsp_pc, rsp_pc_nxt, target;
  logic [CW:0]     outstanding, out_nxt, drop_cnt, drop_cnt_nxt, q_count;
  logic [CW+1:0]   inflight;
  logic            req_fire, rsp_ok, q_push, q_pop, q_full, q_empty;
  inst_ent_t       q_in, q_head;

  assign target   = redirect_pc & ~32'd3;
  assign inflight = {1'b0, q_count} + {1'b0, outstanding};

  // Gated by rst_n so the request drops immediately when reset asserts.
  assign imem_req_valid = rst_n && (state == RUN) && !redirect_valid && (inflight < QD);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && (outstanding != '0);
  assign out_nxt        = outstanding + {{CW{1'b0}}, req_fire} - {{CW{1'b0}}, rsp_ok};

  // Responses in RUN are contiguous from the last redirect, so one running PC tags them.
  assign q_push  = (state == RUN) && rsp_ok && !redirect_valid;
  assign q_in.pc   = rsp_pc;
  assign q_in.data = imem_rsp_data;
  assign q_pop   = inst_valid && inst_ready;

  fetch_queue #(
    .WIDTH (2*XLEN),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (q_push),
    .push_dat (q_in),
    .pop      (q_pop),
    .pop_dat  (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign inst_valid = !q_empty;
  assign inst_data  = inst_valid ? q_head.data : '0;
  assign inst_pc    = inst_valid ? q_head.pc   : '0;
  assign inst_pc4   = inst_pc + 32'd4;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    rsp_pc_nxt   = rsp_pc;
    drop_cnt_nxt = drop_cnt;
    if (req_fire) fetch_pc_nxt = fetch_pc + 32'd4;
    if (state == RUN) begin
      if (q_push) rsp_pc_nxt = rsp_pc + 32'd4;
      if (redirect_valid && (out_nxt != '0)) begin
        state_nxt    = FLUSH;
        drop_cnt_nxt = out_nxt;
      end
    end else begin
      drop_cnt_nxt = drop_cnt - {{CW{1'b0}}, rsp_ok};
      if (drop_cnt_nxt == '0) state_nxt = RUN;
    end
    if (redirect_valid) begin
      fetch_pc_nxt = target;
      rsp_pc_nxt   = target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= out_nxt;
      drop_cnt    <= drop_cnt_nxt;
    end
  end

  a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outstanding == '0)));
  a_push_on_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(q_push && q_full && !q_pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model of configurable latency.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc, inst_pc4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mem_lat = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc4(inst_pc4)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return ~a;
  endfunction

  // One clock: record an accepted request, then present the next due response.
  task automatic tick();
    logic fired;
    logic [31:0] a;
    fired = imem_req_valid && imem_req_ready;
    a = imem_req_addr;
    @(posedge clk); #1;
    cyc++;
    if (fired) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc + mem_lat - 1);
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1; mem_lat = 1;
    pend_addr.delete(); pend_due.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    #2;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got %0b exp 0", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_req_addr got %h exp 0", imem_req_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got %0b exp 0", inst_valid); end
    total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL reset_inst_data got %h exp 0", inst_data); end
    total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
    total++; if (inst_pc4 !== 32'h4) begin bad++; $display("FAIL reset_inst_pc4 got %h exp 4", inst_pc4); end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(i*4)) begin bad++; $display("FAIL basic_req[%0d] got v=%0b a=%h exp v=1 a=%h", i, imem_req_valid, imem_req_addr, 32'(i*4)); end
      end
      if (i >= 2) begin
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'((i-2)*4) || inst_pc4 !== 32'((i-1)*4) || inst_data !== ~32'((i-2)*4)) begin bad++; $display("FAIL basic_inst[%0d] got v=%0b pc=%h pc4=%h d=%h exp pc=%h", i, inst_valid, inst_pc, inst_pc4, inst_data, 32'((i-2)*4)); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_req_ready = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL stall_c0 got v=%0b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL stall_hold got v=%0b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    #1;
    tick();
    total++; if (imem_req_addr !== 32'h4) begin bad++; $display("FAIL stall_advance got %h exp 4", imem_req_addr); end
  endtask

  task automatic test_full();
    int reqs;
    do_reset();
    inst_ready = 1'b0;
    reqs = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid && imem_req_ready) reqs++;
      tick();
    end
    total++; if (reqs !== 4) begin bad++; $display("FAIL full_reqs got %0d exp 4", reqs); end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid got %0b exp 0", imem_req_valid); end
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL full_head got v=%0b pc=%h exp v=1 pc=0", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_flush();
    bit found;
    do_reset();
    mem_lat = 3;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL flush_redir_req got %0b exp 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL flush_c1 got req=%0b inst=%0b exp 0 0", imem_req_valid, inst_valid); end
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL flush_c2 got %0b exp 0", imem_req_valid); end
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin bad++; $display("FAIL flush_resume got v=%0b a=%h exp v=1 a=100", imem_req_valid, imem_req_addr); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inst_valid) begin
        found = 1'b1;
        total++; if (inst_pc !== 32'h100 || inst_data !== ~32'h100) begin bad++; $display("FAIL flush_first_inst got pc=%h d=%h exp pc=100", inst_pc, inst_data); end
      end else tick();
    end
    total++; if (!found) begin bad++; $display("FAIL flush_timeout got none exp inst_valid"); end
  endtask

  task automatic test_redirect_rsp_pop();
    do_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    #1;
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_req_valid !== 1'b0) begin bad++; $display("FAIL rrp_pop got v=%0b pc=%h req=%0b exp 1 0 0", inst_valid, inst_pc, imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rrp_empty got %0b exp 0", inst_valid); end
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin bad++; $display("FAIL rrp_addr got v=%0b a=%h exp v=1 a=200", imem_req_valid, imem_req_addr); end
    tick();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rrp_dropped got %0b exp 0", inst_valid); end
    tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin bad++; $display("FAIL rrp_inst got v=%0b pc=%h exp v=1 pc=200", inst_valid, inst_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got v=%0b a=%h exp v=1 a=fffffffc", imem_req_valid, imem_req_addr); end
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero got v=%0b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
    tick();
    total++; if (inst_pc !== 32'hFFFF_FFFC || inst_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got pc=%h pc4=%h exp fffffffc 0", inst_pc, inst_pc4); end
    tick();
    total++; if (inst_pc !== 32'h0 || inst_pc4 !== 32'h4) begin bad++; $display("FAIL wrap_next got pc=%h pc4=%h exp 0 4", inst_pc, inst_pc4); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    mem_lat = 4;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rf_in_flush got %0b exp 0", imem_req_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL rf_req got v=%0b a=%h exp 0 0", imem_req_valid, imem_req_addr); end
    total++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0 || inst_pc4 !== 32'h4) begin bad++; $display("FAIL rf_inst got v=%0b d=%h pc=%h pc4=%h exp 0 0 0 4", inst_valid, inst_data, inst_pc, inst_pc4); end
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; mem_lat = 1;
    pend_addr.delete(); pend_due.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL rf_release got v=%0b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
    tick(); tick();
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL rf_run got v=%0b pc=%h exp v=1 pc=0", inst_valid, inst_pc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_redirect_flush();
    test_redirect_rsp_pop();
    test_wrap();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
